// File: rtl/matrix_mem_pkg.sv
// Shared defaults, state encoding and address-check helper for the
// matrix memory responder and its word array.
package matrix_mem_pkg;

   localparam int MM_DATA_W  = 32;
   localparam int MM_DEPTH   = 64;
   localparam int MM_LATENCY = 2;

   // Wide enough for the largest supported latency (15).
   localparam int MM_CNT_W = 4;

   // Every bit of rd_data takes this value when an errored read completes.
   localparam logic MM_ERR_RD_FILL = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mm_state_t;

   // A request is rejected when the byte address is not word aligned or the
   // word index falls outside the array.
   function automatic logic mm_addr_bad(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM with registered read. The read register
// only updates on a read access, so it holds its value across writes.
module mem_word_array
   import matrix_mem_pkg::*;
#(
   parameter int DATA_W = MM_DATA_W,
   parameter int DEPTH  = MM_DEPTH,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Contents are deliberately not reset; only the access port is clocked.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/matrix_mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, completes
// it LATENCY cycles after the strobe with a one-cycle done pulse.
module matrix_mem_responder
   import matrix_mem_pkg::*;
#(
   parameter int DATA_W  = MM_DATA_W,
   parameter int DEPTH   = MM_DEPTH,
   parameter int LATENCY = MM_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_memory_transaction,
   input  logic              req_write,
   input  logic [31:0]       address_in,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              done_memory_transaction,
   output logic              busy,
   output logic              err
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = MM_CNT_W;

   mm_state_t         state_d, state_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic [AW-1:0]     addr_d, addr_q;
   logic              write_d, write_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;
   logic              bad_d, bad_q;
   logic [DATA_W-1:0] rd_hold_d, rd_hold_q;

   logic              req_bad;
   logic [AW-1:0]     req_index;
   logic              ram_en;
   logic              ram_we;
   logic [AW-1:0]     ram_addr;
   logic [DATA_W-1:0] ram_rdata;
   logic              resp_read;

   assign req_bad   = mm_addr_bad(address_in, DEPTH);
   assign req_index = address_in[AW+1:2];

   // Next-state logic; the RAM read is launched on the edge that enters RESP
   // so the word is available during the done cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      bad_d    = bad_q;
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = addr_q;
      case (state_q)
         IDLE: begin
            if (start_memory_transaction) begin
               addr_d  = req_index;
               write_d = req_write;
               wdata_d = wr_data;
               bad_d   = req_bad;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d  = RESP;
                  ram_addr = req_index;
                  ram_en   = !req_write && !req_bad;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               ram_en  = !write_q && !bad_q;
            end
         end
         RESP: begin
            state_d = IDLE;
            ram_en  = write_q && !bad_q;
            ram_we  = write_q && !bad_q;
         end
         default: state_d = IDLE;
      endcase
      // A reset aborts the request: nothing may reach the array.
      if (rst) begin
         ram_en = 1'b0;
         ram_we = 1'b0;
      end
   end

   // Output decode and read-data hold selection.
   always_comb begin
      done_memory_transaction = (state_q == RESP);
      busy                    = (state_q != IDLE);
      err                     = done_memory_transaction && bad_q;
      resp_read               = done_memory_transaction && !write_q;
      rd_data                 = rd_hold_q;
      if (resp_read) begin
         rd_data = bad_q ? {DATA_W{MM_ERR_RD_FILL}} : ram_rdata;
      end
      rd_hold_d = resp_read ? rd_data : rd_hold_q;
   end

   // State and request registers; reset wins over any coincident strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         bad_q     <= 1'b0;
         rd_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         bad_q     <= bad_d;
         rd_hold_q <= rd_hold_d;
      end
   end

   mem_word_array #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(wdata_q),
      .rdata(ram_rdata)
   );

endmodule

// File: doc/matrix_mem_responder.md
MATRIX_MEM_RESPONDER -- requirements
Module: matrix_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one memory word.
REQ-002 SHALL have parameter DEPTH, default 64, number of words held.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request to completion; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start_memory_transaction  input  1  request strobe from initiator.
REQ-007 SHALL have port req_write  input  1  1 = write, 0 = read; sampled with the strobe.
REQ-008 SHALL have port address_in  input  32  byte address from initiator; word index = address_in[31:2].
REQ-009 SHALL have port wr_data  input  DATA_W  write data; sampled with the strobe.
REQ-010 SHALL have port rd_data  output  DATA_W  read data, valid in the done cycle and held afterwards.
REQ-011 SHALL have port done_memory_transaction  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high while a request is outstanding.
REQ-013 SHALL have port err  output  1  error flag, qualified by done_memory_transaction.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL, in IDLE with strobe high, latch address, req_write and wr_data, load latency counter with LATENCY-1, and enter WAIT (or RESP directly when LATENCY = 1).
REQ-016 SHALL decrement the counter each WAIT cycle and enter RESP when it reaches zero.
REQ-017 SHALL assert done_memory_transaction for exactly the one RESP cycle, LATENCY cycles after the strobe edge, then return to IDLE.
REQ-018 SHALL ignore the strobe in WAIT and RESP; no queuing; minimum request spacing is LATENCY+1 cycles.
REQ-019 SHALL drive busy high in WAIT and RESP, low in IDLE.
REQ-020 SHALL flag error when address_in[1:0] != 0 or word index >= DEPTH.
REQ-021 SHALL, on error, assert err with done, not modify memory, and drive rd_data = 0 for reads.
REQ-022 SHALL commit a valid write on the RESP edge; a read issued later returns the new value.
REQ-023 SHALL, on a valid read, present the stored word on rd_data in the RESP cycle and hold it until the next read completes.
REQ-024 SHALL leave rd_data unchanged on write completions.
REQ-025 SHALL hold err low outside done cycles.

Reset
REQ-026 SHALL, with rst high, force state IDLE, counter 0, done_memory_transaction 0, busy 0, err 0, rd_data 0.
REQ-027 SHALL, on rst mid-transaction, abort: no write committed, no done pulse issued.
REQ-028 SHALL NOT clear memory contents on reset.
REQ-029 SHALL give rst priority over a coincident strobe.

Structure
REQ-030 SHALL place DATA_W/DEPTH/LATENCY defaults, IDLE/WAIT/RESP encodings and the error read value in shared package matrix_mem_pkg.
REQ-031 SHALL instantiate one sub-module mem_word_array: single-port synchronous RAM, DEPTH x DATA_W, with write enable.

Verification
REQ-032 SHALL cover: write 0x0000_1234 to address 0x10, then read 0x10 -> done exactly 2 cycles after each strobe, rd_data = 0x0000_1234, err = 0.
REQ-033 SHALL cover: strobe at address 0x12 (misaligned) with write 0xFFFF_FFFF -> done + err = 1; a subsequent read of 0x10 still returns 0x0000_1234.
REQ-034 SHALL cover: read at address 0x100 (index 64 >= DEPTH) -> done + err = 1, rd_data = 0.
REQ-035 SHALL cover: second strobe one cycle after the first -> ignored; exactly one done pulse; busy high for 2 cycles.
REQ-036 SHALL cover: rst during WAIT of a write 0xAAAA_5555 to 0x04 -> no done pulse; a later read of 0x04 returns the prior value.
REQ-037 SHALL cover: 18 sequential reads at 0x00..0x44 (mimicking a 3x3 A/B load) -> 18 done pulses, each LATENCY cycles after its strobe, and data matches the preloaded values.
